// File: rtl/nand3_bist.sv
// Built-in self test for a single NAND3 cell: sweeps all eight input vectors,
// waits for the cell to settle, samples its output and tallies mismatches.
module nand3_bist #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned PASSES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ZN_IN,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic [2:0] FIRST_FAIL
);

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);
  localparam logic [3:0] PassLast   = 4'(PASSES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StFinish} state_e;

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] pass_cnt_q, pass_cnt_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [3:0] err_q, err_d;
  logic [2:0] first_q, first_d;
  logic       ok_q, ok_d;
  logic       mismatch;

  // Expected NAND3 output is low only for the all-ones vector.
  assign mismatch = (ZN_IN != ~(&vec_q));

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    pass_cnt_d   = pass_cnt_q;
    settle_cnt_d = settle_cnt_q;
    err_d        = err_q;
    first_d      = first_q;
    ok_d         = ok_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d      = StSettle;
          vec_d        = 3'd0;
          pass_cnt_d   = 4'd0;
          settle_cnt_d = 4'd0;
          err_d        = 4'd0;
          first_d      = 3'd0;
          ok_d         = 1'b0;
        end
      end
      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          state_d      = StSample;
          settle_cnt_d = 4'd0;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      StSample: begin
        if (mismatch) begin
          // A zero count means no earlier mismatch in this run.
          if (err_q == 4'd0) first_d = vec_q;
          if (err_q != 4'd15) err_d = err_q + 4'd1;
        end
        if (vec_q == 3'd7 && pass_cnt_q == PassLast) begin
          state_d = StFinish;
          vec_d   = 3'd0;
          ok_d    = (err_d == 4'd0);
        end else begin
          state_d = StSettle;
          vec_d   = vec_q + 3'd1;
          if (vec_q == 3'd7) pass_cnt_d = pass_cnt_q + 4'd1;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      vec_q        <= 3'd0;
      pass_cnt_q   <= 4'd0;
      settle_cnt_q <= 4'd0;
      err_q        <= 4'd0;
      first_q      <= 3'd0;
      ok_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      pass_cnt_q   <= pass_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      err_q        <= err_d;
      first_q      <= first_d;
      ok_q         <= ok_d;
    end
  end

  // vec_q is forced to zero outside a run, so the stimulus idles low.
  assign A1         = vec_q[0];
  assign A2         = vec_q[1];
  assign A3         = vec_q[2];
  assign BUSY       = (state_q == StSettle) || (state_q == StSample);
  assign DONE       = (state_q == StFinish);
  assign PASS       = ok_q;
  assign ERR_CNT    = err_q;
  assign FIRST_FAIL = first_q;

endmodule

// File: tb/tb_nand3_bist.sv
// Randomized bench for nand3_bist: two instances (default and PASSES=4/SETTLE=1)
// driven by truth-table cell models and checked against a sweep-level model.
module tb_nand3_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [2];
  logic       start [2];
  logic       zn    [2];
  logic       a1    [2];
  logic       a2    [2];
  logic       a3    [2];
  logic       busy  [2];
  logic       done  [2];
  logic       pass  [2];
  logic [3:0] err   [2];
  logic [2:0] ff    [2];
  logic [7:0] tt    [2];

  int checks   = 0;
  int failures = 0;

  // Cell under test modelled as an arbitrary truth table over {A3,A2,A1}.
  assign zn[0] = tt[0][{a3[0], a2[0], a1[0]}];
  assign zn[1] = tt[1][{a3[1], a2[1], a1[1]}];

  nand3_bist dut0 (
    .CLK(clk), .RST(rst[0]), .START(start[0]), .ZN_IN(zn[0]),
    .A1(a1[0]), .A2(a2[0]), .A3(a3[0]), .BUSY(busy[0]), .DONE(done[0]),
    .PASS(pass[0]), .ERR_CNT(err[0]), .FIRST_FAIL(ff[0])
  );

  nand3_bist #(.SETTLE(1), .PASSES(4)) dut1 (
    .CLK(clk), .RST(rst[1]), .START(start[1]), .ZN_IN(zn[1]),
    .A1(a1[1]), .A2(a2[1]), .A3(a3[1]), .BUSY(busy[1]), .DONE(done[1]),
    .PASS(pass[1]), .ERR_CNT(err[1]), .FIRST_FAIL(ff[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int settle_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int passes_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Sweep-level reference: good NAND3 output is 1 except for vector 7.
  function automatic void model(input logic [7:0] t, input int p,
                                output int errs, output int first);
    int raw = 0;
    logic good;
    first = 0;
    for (int pi = 0; pi < p; pi++) begin
      for (int v = 0; v < 8; v++) begin
        good = (v != 7);
        if (t[v] != good) begin
          if (raw == 0) first = v;
          raw++;
        end
      end
    end
    errs = (raw > 15) ? 15 : raw;
  endfunction

  task automatic check_idle_zero(input int d, input string tag);
    check_eq({tag, "_vec"}, {29'd0, a3[d], a2[d], a1[d]}, 0);
    check_eq({tag, "_busy"}, busy[d], 0);
    check_eq({tag, "_done"}, done[d], 0);
    check_eq({tag, "_pass"}, pass[d], 0);
    check_eq({tag, "_err"}, err[d], 0);
    check_eq({tag, "_ff"}, ff[d], 0);
  endtask

  task automatic run(input int d, input logic [7:0] t, input bit noise);
    int errs, first, n, s, p;
    s = settle_of(d);
    p = passes_of(d);
    model(t, p, errs, first);
    tt[d]    = t;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    check_eq("start_busy", busy[d], 1);
    check_eq("start_err", err[d], 0);
    check_eq("start_pass", pass[d], 0);
    n = 0;
    while (busy[d] === 1'b1 && n < 2000) begin
      check_eq("vec", {29'd0, a3[d], a2[d], a1[d]}, (n / (s + 1)) % 8);
      if (noise) start[d] = 1'($urandom_range(0, 1));
      n++;
      @(negedge clk);
    end
    start[d] = 1'b0;
    check_eq("busy_len", n, 8 * (s + 1) * p);
    check_eq("fin_done", done[d], 1);
    check_eq("fin_pass", pass[d], (errs == 0) ? 1 : 0);
    check_eq("fin_err", err[d], errs);
    check_eq("fin_ff", ff[d], first);
    check_eq("fin_vec", {29'd0, a3[d], a2[d], a1[d]}, 0);
    @(negedge clk);
    check_eq("idle_done", done[d], 0);
    check_eq("idle_busy", busy[d], 0);
    check_eq("hold_pass", pass[d], (errs == 0) ? 1 : 0);
    check_eq("hold_err", err[d], errs);
    check_eq("hold_ff", ff[d], first);
  endtask

  initial begin
    int n;
    int done_seen;
    for (int d = 0; d < 2; d++) begin
      rst[d]   = 1'b1;
      start[d] = 1'b0;
      tt[d]    = 8'h7F;
    end
    repeat (3) @(negedge clk);
    check_idle_zero(0, "rst0");
    check_idle_zero(1, "rst1");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // Directed cell behaviours: good, stuck-at-1, stuck-at-0.
    run(0, 8'h7F, 1'b0);
    run(0, 8'hFF, 1'b0);
    run(0, 8'h00, 1'b0);
    run(1, 8'h00, 1'b0);
    run(1, 8'h7F, 1'b0);

    // Reset mid-run, with START high alongside it.
    tt[0]    = 8'h00;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (busy[0] === 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    check_eq("abort_busy_cnt", n, 10);
    rst[0]   = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    check_idle_zero(0, "abort");
    @(negedge clk);
    check_eq("rst_start_busy", busy[0], 0);
    rst[0]   = 1'b0;
    start[0] = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) done_seen++;
    end
    check_eq("abort_no_done", done_seen, 0);
    run(0, 8'h7F, 1'b0);

    // START held continuously: next run starts right after the IDLE cycle.
    start[0] = 1'b1;
    n = 0;
    while (done[0] !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_eq("held_done1", done[0], 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy[0] !== 1'b1 && n < 5);
    check_eq("held_restart", n, 2);
    start[0] = 1'b0;
    n = 0;
    while (done[0] !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_eq("held_done2", done[0], 1);
    @(negedge clk);

    // Random cells with START noise during the run.
    for (int i = 0; i < 6; i++) run(0, 8'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) run(1, 8'($urandom), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
